sd_hex_dump_formatter: RTL and testbench
========================================

// Module: sd_hex_dump_formatter
// PURPOSE
//  Sits between sd_file_reader (outreq/outbyte) and uart_tx (wreq/wgnt/wdata). Buffers the file-content
//  byte stream, which has no backpressure, and renders each byte as uppercase ASCII hex. Bytes are
//  separated by spaces, and CR LF ends every BYTES_PER_LINE bytes, giving a readable hex dump on the
//  UART. On end of file it flushes a partial last line and reports completion.
// PARAMETERS
//  FIFO_ASIZE      6    input FIFO depth = 2**FIFO_ASIZE bytes
//  BYTES_PER_LINE  16   bytes per output line, legal range 1..255
// PORTS
//  clk          in   1   single clock; all logic is rising-edge
//  rst          in   1   synchronous, active-high reset
//  in_req       in   1   one-cycle strobe: in_byte is valid (sd_file_reader outreq)
//  in_byte      in   8   file content byte (sd_file_reader outbyte)
//  in_done      in   1   one-cycle strobe: file fully read, no further in_req follows
//  out_req      out  1   output character valid; held until accepted
//  out_data     out  8   ASCII character
//  out_gnt      in   1   consumer accept; transfer = out_req & out_gnt in the same cycle
//  overflow     out  1   sticky: at least one input byte was dropped because the FIFO was full
//  flushed      out  1   sticky: in_done seen, all bytes and the trailing CR LF are sent
//  byte_count   out  32  number of bytes accepted into the FIFO, saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  Reset (rst=1 at a clock edge): out_req=0, out_data=8'h00, overflow=0, flushed=0, byte_count=0.
//   Also clears FIFO pointers, the line counter and the done latch; FSM goes to IDLE.
//   Reset mid-character abandons the character; out_req drops on the next cycle.
//  FIFO write: in_req & !full pushes in_byte and increments byte_count.
//   in_req & full drops the byte and sets overflow. Full is judged on the registered count,
//   so a pop in the same cycle does not make room.
//   Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
//  Output handshake: out_data must stay stable while out_req=1 and out_gnt=0.
//   After a transfer, the next character may be presented in the very next cycle
//   (back-to-back, one char/cycle when out_gnt is held at 1).
//  FSM states and transitions:
//   IDLE : if FIFO not empty -> pop byte into cur, out_data=hex(cur[7:4]), out_req=1, go HI.
//          else if done latch & line_cnt!=0 & !flushed -> out_data=8'h0D, go CR.
//          else if done latch & line_cnt==0 -> flushed=1.
//   HI   : on transfer -> out_data=hex(cur[3:0]), go LO.
//   LO   : on transfer -> line_cnt+1; if line_cnt+1==BYTES_PER_LINE -> line_cnt=0, out_data=8'h0D, go CR;
//          else out_data=8'h20, go SEP.
//   SEP  : on transfer -> same as IDLE evaluated in this cycle; pop the next byte if present,
//          else out_req=0 and go IDLE.
//   CR   : on transfer -> out_data=8'h0A, go LF.
//   LF   : on transfer -> line_cnt=0; go IDLE and drop out_req, or chain the next byte as in SEP.
//  hex(n): n<10 -> 8'h30+n; n>=10 -> 8'h37+n (uppercase A-F).
//  Latency: in_req at edge t with FIFO empty and FSM IDLE -> out_req=1 with the high nibble at edge t+2.
//  The trailing space before a line break is never emitted; the line ends "...XX\r\n".
//  in_done: latched. When the FIFO drains with line_cnt!=0, emit exactly one CR LF, then set flushed.
//   An in_done arriving while bytes are queued has no effect until the FIFO is empty.
//   in_req after in_done is still accepted; flushed is set only once the FSM goes idle
//   with an empty FIFO.
//  line_cnt width: 8 bits; byte_count saturates rather than wraps.
// TESTING
//  1 Reset: assert rst with out_req pending -> next cycle out_req=0, overflow=0, flushed=0, byte_count=0.
//  2 BYTES_PER_LINE=4, out_gnt=1, bytes 00 1F A5 FF 3C, then in_done ->
//    stream "00 1F A5 FF\r\n3C\r\n"; flushed=1; byte_count=5.
//  3 Backpressure: out_gnt toggles 1/0 randomly over 100 bytes ->
//    out_data never changes while out_req=1 & out_gnt=0; output matches the golden dump exactly.
//  4 Overflow: FIFO_ASIZE=2, out_gnt=0, 6 consecutive in_req ->
//    overflow=1 and byte_count=4 (or 5 if the FSM popped one); after release only the accepted bytes appear.
//  5 Exact line end: BYTES_PER_LINE=2, bytes AB CD, then in_done ->
//    "AB CD\r\n" with no second CR LF; flushed=1.
//  6 Latency: single in_req at cycle 10 while idle -> out_req rises at cycle 12 with out_data=8'h41 for byte 8'hA0.

Source files
------------

// File: rtl/sd_hex_dump_formatter.sv
`default_nettype none
// ============================================================================
// sd_hex_dump_formatter : buffers a byte stream and renders it on a character
// handshake as an uppercase hex dump ("XX XX ...\r\n").         Rev 1.0
// ============================================================================
module sd_hex_dump_formatter #(
  parameter int FIFO_ASIZE     = 6,
  parameter int BYTES_PER_LINE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_req,
  input  logic [7:0]  in_byte,
  input  logic        in_done,
  output logic        out_req,
  output logic [7:0]  out_data,
  input  logic        out_gnt,
  output logic        overflow,
  output logic        flushed,
  output logic [31:0] byte_count
);

  localparam int         C_DEPTH = 1 << FIFO_ASIZE;
  localparam logic [7:0] C_BPL   = 8'(BYTES_PER_LINE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_SEP  = 3'd3,
    S_CR   = 3'd4,
    S_LF   = 3'd5
  } state_t;

  logic [7:0]            r_mem [C_DEPTH];
  logic [FIFO_ASIZE-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_ASIZE:0]   r_count;
  logic                  w_full, w_empty, w_push, w_pop;
  logic [7:0]            w_head;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cur, w_cur_nxt;
  logic [7:0] r_line_cnt, w_lc_nxt, w_lc_eff, w_lc_inc;
  logic       r_sep_pend, w_sep_nxt;
  logic       r_done;
  logic       w_req_nxt, w_flushed_nxt, w_launch, w_xfer;
  logic [7:0] w_data_nxt;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign w_full   = (r_count == (FIFO_ASIZE+1)'(C_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = in_req & ~w_full;
  assign w_head   = r_mem[r_rd_ptr];
  assign w_xfer   = out_req & out_gnt;
  assign w_lc_inc = r_line_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      overflow   <= 1'b0;
      byte_count <= '0;
      r_done     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (in_req && w_full) overflow <= 1'b1;
      if (w_push && (byte_count != 32'hFFFF_FFFF)) byte_count <= byte_count + 32'd1;
      if (in_done) r_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cur      <= '0;
      r_line_cnt <= '0;
      r_sep_pend <= 1'b0;
      out_req    <= 1'b0;
      out_data   <= 8'h00;
      flushed    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur      <= w_cur_nxt;
      r_line_cnt <= w_lc_nxt;
      r_sep_pend <= w_sep_nxt;
      out_req    <= w_req_nxt;
      out_data   <= w_data_nxt;
      flushed    <= w_flushed_nxt;
    end
  end

  // The separator is deferred until the next byte is actually present, so a
  // line never ends with a space even when the stream stalls mid-line.
  always_comb begin
    w_state_nxt   = r_state;
    w_cur_nxt     = r_cur;
    w_lc_nxt      = r_line_cnt;
    w_lc_eff      = r_line_cnt;
    w_sep_nxt     = r_sep_pend;
    w_req_nxt     = out_req;
    w_data_nxt    = out_data;
    w_flushed_nxt = flushed;
    w_pop         = 1'b0;
    w_launch      = 1'b0;
    case (r_state)
      S_IDLE: w_launch = 1'b1;
      S_HI: if (w_xfer) begin
        w_data_nxt  = hex_char(r_cur[3:0]);
        w_state_nxt = S_LO;
      end
      S_LO: if (w_xfer) begin
        if (w_lc_inc == C_BPL) begin
          w_lc_nxt    = 8'd0;
          w_data_nxt  = 8'h0D;
          w_state_nxt = S_CR;
        end else begin
          w_lc_nxt = w_lc_inc;
          if (!w_empty) begin
            w_data_nxt  = 8'h20;
            w_state_nxt = S_SEP;
          end else begin
            w_req_nxt   = 1'b0;
            w_sep_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_SEP: if (w_xfer) w_launch = 1'b1;
      S_CR: if (w_xfer) begin
        w_data_nxt  = 8'h0A;
        w_state_nxt = S_LF;
      end
      S_LF: if (w_xfer) begin
        w_lc_nxt = 8'd0;
        w_lc_eff = 8'd0;
        w_launch = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_launch) begin
      if (!w_empty) begin
        w_req_nxt = 1'b1;
        if (r_sep_pend) begin
          w_sep_nxt   = 1'b0;
          w_data_nxt  = 8'h20;
          w_state_nxt = S_SEP;
        end else begin
          w_pop       = 1'b1;
          w_cur_nxt   = w_head;
          w_data_nxt  = hex_char(w_head[7:4]);
          w_state_nxt = S_HI;
        end
      end else if (r_done && (w_lc_eff != 8'd0) && !flushed) begin
        w_req_nxt   = 1'b1;
        w_sep_nxt   = 1'b0;
        w_data_nxt  = 8'h0D;
        w_state_nxt = S_CR;
      end else begin
        w_req_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
        if (r_done && (w_lc_eff == 8'd0)) w_flushed_nxt = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_hex_dump_formatter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_sd_hex_dump_formatter : directed table plus corner sequences for the
// hex dump formatter (FIFO depth 4, 4 bytes per line).          Rev 1.0
// ============================================================================
module tb_sd_hex_dump_formatter;

  localparam string CRLF = "\015\012";

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_req = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_done = 1'b0;
  logic        out_req;
  logic [7:0]  out_data;
  logic        out_gnt = 1'b0;
  logic        overflow;
  logic        flushed;
  logic [31:0] byte_count;

  sd_hex_dump_formatter #(.FIFO_ASIZE(2), .BYTES_PER_LINE(4)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_byte(in_byte), .in_done(in_done),
    .out_req(out_req), .out_data(out_data), .out_gnt(out_gnt),
    .overflow(overflow), .flushed(flushed), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails = 0;
  int hold_viol = 0;
  bit rand_gnt = 1'b0;
  logic [7:0] got[$];
  logic [7:0] exq[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Collect transfers and watch data stability while stalled.
  always @(negedge clk) begin
    if (!rst && out_req && out_gnt) got.push_back(out_data);
    if (!rst && prev_hold && out_req && (out_data !== prev_data)) hold_viol++;
    prev_hold = !rst && out_req && !out_gnt;
    prev_data = out_data;
  end

  typedef struct {
    int         n;
    logic [7:0] b [6];
    string      exp;
  } vec_t;
  vec_t tbl [3];

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_gnt) out_gnt = 1'($urandom_range(0, 1));
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic check_stream(input string nm);
    int bad;
    check({nm, " length"}, got.size(), exq.size());
    bad = -1;
    for (int i = 0; i < got.size() && i < exq.size(); i++)
      if (bad < 0 && got[i] !== exq[i]) bad = i;
    vectors++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s char %0d: got %02h, expected %02h", nm, bad, got[bad], exq[bad]);
    end
  endtask

  task automatic set_exp(input string s);
    exq.delete();
    for (int i = 0; i < s.len(); i++) exq.push_back(s[i]);
  endtask

  function automatic logic [7:0] hc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_req = 1'b0; in_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    got.delete();
  endtask

  task automatic send(input logic [7:0] b);
    in_req = 1'b1; in_byte = b;
    tick();
    in_req = 1'b0;
  endtask

  task automatic finish_stream(input string nm);
    int k;
    in_done = 1'b1; tick(); in_done = 1'b0;
    k = 0;
    while (flushed !== 1'b1 && k < 3000) begin tick(); k++; end
    check({nm, " flushed"}, flushed, 1'b1);
    for (int i = 0; i < 12; i++) tick();
    check_stream(nm);
  endtask

  logic [7:0] rb [100];
  logic [31:0] cnt;

  initial begin
    tbl[0].n = 5; tbl[0].b = '{8'h00, 8'h1F, 8'hA5, 8'hFF, 8'h3C, 8'h00};
    tbl[0].exp = {"00 1F A5 FF", CRLF, "3C", CRLF};
    tbl[1].n = 4; tbl[1].b = '{8'hAB, 8'hCD, 8'h09, 8'h7E, 8'h00, 8'h00};
    tbl[1].exp = {"AB CD 09 7E", CRLF};
    tbl[2].n = 6; tbl[2].b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    tbl[2].exp = {"12 34 56 78", CRLF, "9A BC", CRLF};

    do_reset();
    check("reset out_req", out_req, 1'b0);
    check("reset out_data", out_data, 8'h00);
    check("reset flushed", flushed, 1'b0);
    check("reset byte_count", byte_count, 32'd0);

    for (int v = 0; v < 3; v++) begin
      do_reset();
      out_gnt = 1'b1;
      for (int i = 0; i < tbl[v].n; i++) begin
        send(tbl[v].b[i]);
        tick();
      end
      check($sformatf("vec%0d flushed early", v), flushed, 1'b0);
      set_exp(tbl[v].exp);
      finish_stream($sformatf("vec%0d", v));
      check($sformatf("vec%0d byte_count", v), byte_count, 32'(tbl[v].n));
      check($sformatf("vec%0d overflow", v), overflow, 1'b0);
    end

    // First character appears two edges after in_req is raised.
    do_reset();
    out_gnt = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    in_req = 1'b1; in_byte = 8'hA0;
    tick();
    in_req = 1'b0;
    check("latency t+1 out_req", out_req, 1'b0);
    tick();
    check("latency t+2 out_req", out_req, 1'b1);
    check("latency t+2 out_data", out_data, 8'h41);

    // Overflow under full stall, then drain what was accepted.
    do_reset();
    out_gnt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_req = 1'b1; in_byte = 8'((i + 1) * 8'h11);
      tick();
    end
    in_req = 1'b0;
    tick();
    cnt = byte_count;
    check("ovf overflow", overflow, 1'b1);
    check("ovf byte_count 4 or 5", 32'(cnt == 32'd4 || cnt == 32'd5), 32'd1);
    out_gnt = 1'b1;
    if (cnt == 32'd5) set_exp({"11 22 33 44", CRLF, "55", CRLF});
    else set_exp({"11 22 33 44", CRLF});
    finish_stream("ovf drain");

    // Reset with a character pending and sticky flags set.
    out_gnt = 1'b0;
    for (int i = 0; i < 6; i++) send(8'h5A);
    tick();
    check("pre-reset out_req", out_req, 1'b1);
    check("pre-reset overflow", overflow, 1'b1);
    rst = 1'b1;
    tick();
    check("rst out_req", out_req, 1'b0);
    check("rst out_data", out_data, 8'h00);
    check("rst overflow", overflow, 1'b0);
    check("rst flushed", flushed, 1'b0);
    check("rst byte_count", byte_count, 32'd0);
    rst = 1'b0;

    // Random backpressure over 100 bytes.
    do_reset();
    hold_viol = 0;
    rand_gnt = 1'b1;
    exq.delete();
    for (int i = 0; i < 100; i++) rb[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 100; i++) begin
      exq.push_back(hc(rb[i][7:4]));
      exq.push_back(hc(rb[i][3:0]));
      if ((i % 4) == 3 || i == 99) begin
        exq.push_back(8'h0D);
        exq.push_back(8'h0A);
      end else begin
        exq.push_back(8'h20);
      end
    end
    for (int i = 0; i < 100; i++) begin
      send(rb[i]);
      for (int j = 0; j < 11; j++) tick();
    end
    finish_stream("backpressure");
    rand_gnt = 1'b0;
    check("bp byte_count", byte_count, 32'd100);
    check("bp overflow", overflow, 1'b0);
    check("bp data stable while stalled", 32'(hold_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
